id_bypass_ctrl: RTL and testbench
=================================

# id_bypass_ctrl

Parametrised operand bypass and interlock unit for the decode stage. It selects each source operand from the register file or from up to NUM_FWD younger in-flight write-backs, in strict youngest-first priority. It tracks issued loads in a LOAD_LAT-deep shadow pipeline, so only a true load-use dependency raises a stall, and it never forwards or stalls on `$0`. It sits between the register file read ports and the ID→EX bus, and keeps a stall-cycle counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, operand/forward data width
- NUM_FWD, 3, forwarding sources; index 0 is the youngest (EX), then MEM, WB
- LOAD_LAT, 1, cycles after issue before a load's data is forwardable; range 1..4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- id_valid  in  1  decode slot holds a real instruction
- rs, rt  in  5 each  source register addresses
- use_rs, use_rt  in  1 each  instruction reads that source
- is_load  in  1  instruction is a load
- rf_we  in  1  instruction writes the register file
- rf_waddr  in  5  destination register
- rf_rdata1, rf_rdata2  in  DATA_W each  register file read data
- fwd_bus  in  NUM_FWD*(1+5+DATA_W)  packed {we, waddr, wdata}; entry 0 in the most significant slice
- ex_stall  in  1  downstream hold; EX does not accept this cycle
- flush  in  1  squash the decode slot and all tracked loads
- rdata1, rdata2  out  DATA_W each  bypassed operands
- stallreq  out  1  load-use interlock request
- issue  out  1  instruction leaves ID this cycle
- stall_cnt  out  32  cycles with stallreq=1

## Operation
- Each operand: the first forwarding entry i (lowest index) with we=1, waddr≠0, waddr==src supplies the operand; otherwise the rf_rdata value is used. A source address of 0 always yields 0.
- Shadow pipeline: LOAD_LAT entries of {v, addr}.
  - Hazard on a source when use_src=1, src≠0, and any shadow entry has v=1 and addr==src.
  - stallreq = id_valid & ~flush & (hazard_rs | hazard_rt).
- issue = id_valid & ~stallreq & ~ex_stall & ~flush.
- Shadow update on each clock when ~ex_stall:
  - entry0 ← {issue & is_load & rf_we & rf_waddr≠0, rf_waddr}
  - entry k ← entry k−1
- When ex_stall=1 the shadow holds.
- flush clears every v bit on the next edge. flush takes priority over ex_stall.
- stall_cnt increments on every clock with stallreq=1 and saturates at 0xFFFF_FFFF.

## Timing
- Operand mux, stallreq, and issue are combinational, valid in the same cycle as their inputs. No added latency.
- Shadow and counter update on the rising edge.
- Reset (rst=0, asynchronous) forces:
  - all shadow v = 0
  - stall_cnt = 0
  - stallreq = 0 and issue = 0 regardless of id_valid
- Reset mid-stall: stallreq drops immediately. After release, the held instruction is re-evaluated against the empty shadow.
- Load-use with LOAD_LAT=1: the consumer immediately after the load stalls exactly 1 cycle, then takes the data via forwarding entry 1 (MEM).
- A consumer gated by ex_stall is not re-counted as a load-use stall unless the hazard persists.

## Configuration
- ID_FWD_EN defined: behaviour as above.
- ID_FWD_EN undefined: no bypass.
  - rdata1/rdata2 = rf_rdata (0 for `$0`).
  - Hazard additionally asserts for any fwd_bus entry with we=1, waddr≠0, waddr==src.
  - The consumer therefore stalls until the producer has written the register file.

## Structure
- The shared defines header holds: FWD_ENTRY_WD (=1+5+DATA_W), the slice offsets for fwd_bus, and the LOAD_LAT range limits.
- Sub-module id_fwd_mux: one source address plus fwd_bus plus rf data produces the operand and a match flag. It is instantiated twice (rs, rt).
- The shadow pipeline, hazard logic, and stall counter live in the top level.

## Test plan
- Defaults, `lw $5` issued, next `addu $6,$5,$7` → stallreq=1 for 1 cycle, stall_cnt=1. The following cycle issue=1 with rdata1 = MEM wdata 0x1234_5678.
- `addu $3` in EX (wdata 0xA) and in MEM (wdata 0xB) simultaneously, consumer reads `$3` → rdata=0xA, no stall.
- Consumer reads `$0` while EX writes waddr 0 with wdata 0xFFFF_FFFF → rdata=0, stallreq=0.
- Load to `$4`, then ex_stall=1 for 3 cycles with a `$4` consumer in ID → shadow holds, stallreq stays 1 and stall_cnt=3. After ex_stall drops, issue follows per the LOAD_LAT rule.
- Load to `$9` tracked, flush=1 with ex_stall=1 → shadow cleared on the next edge. A subsequent `$9` consumer issues without stalling.
- ID_FWD_EN undefined, WB writes `$2` while ID reads `$2` → stallreq=1 until the fwd entries are clear, then rdata = rf_rdata. rst=0 mid-sequence → stall_cnt=0 and stallreq=0 immediately.

Source files
------------

// File: rtl/id_bypass_ctrl_pkg.sv
// rtl/id_bypass_ctrl_pkg.sv - shared constants and fwd_bus layout helpers for id_bypass_ctrl
//
// fwd_bus entry layout: {we, waddr[4:0], wdata[DATA_W-1:0]}.
// Entry 0 is the youngest source and occupies the most significant slice.
// LOAD_LAT is legal in LOAD_LAT_MIN..LOAD_LAT_MAX.

package id_bypass_ctrl_pkg;

  localparam int REG_AW       = 5;
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 4;

  // FWD_ENTRY_WD: width of one {we, waddr, wdata} entry
  function automatic int fwd_entry_wd(input int data_w);
    return 1 + REG_AW + data_w;
  endfunction

  // Bit offsets inside one entry
  function automatic int fwd_we_ofs(input int data_w);
    return REG_AW + data_w;
  endfunction

  function automatic int fwd_waddr_ofs(input int data_w);
    return data_w;
  endfunction

  // LSB of entry idx inside the packed bus (entry 0 at the top)
  function automatic int fwd_entry_lsb(input int idx, input int num_fwd, input int data_w);
    return (num_fwd - 1 - idx) * fwd_entry_wd(data_w);
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// rtl/id_fwd_mux.sv - per-operand bypass mux with youngest-first priority
//
// Macro: ID_FWD_EN enables the bypass path; without it the operand always
// comes from the register file.
// Ports:
//   src       source register address
//   fwd_bus   NUM_FWD packed {we, waddr, wdata} entries, entry 0 youngest
//   rf_rdata  register file read data
//   data      selected operand (0 for $0)
//   match     some entry writes src (we=1, waddr!=0, waddr==src)

import id_bypass_ctrl_pkg::*;

module id_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_AW-1:0]                       src,
  input  logic [NUM_FWD*fwd_entry_wd(DATA_W)-1:0] fwd_bus,
  input  logic [DATA_W-1:0]                       rf_rdata,
  output logic [DATA_W-1:0]                       data,
  output logic                                    match
);

  logic [NUM_FWD-1:0]             e_we;
  logic [NUM_FWD-1:0][REG_AW-1:0] e_wa;
  logic [NUM_FWD-1:0][DATA_W-1:0] e_wd;
  logic [DATA_W-1:0]              fwd_data;

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_unpack
    localparam int LSB = fwd_entry_lsb(i, NUM_FWD, DATA_W);
    assign e_we[i] = fwd_bus[LSB + fwd_we_ofs(DATA_W)];
    assign e_wa[i] = fwd_bus[LSB + fwd_waddr_ofs(DATA_W) +: REG_AW];
    assign e_wd[i] = fwd_bus[LSB +: DATA_W];
  end

  // Walk oldest to youngest so the youngest hit is the one left standing.
  always_comb begin
    match    = 1'b0;
    fwd_data = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (e_we[i] && (e_wa[i] != '0) && (e_wa[i] == src)) begin
        match    = 1'b1;
        fwd_data = e_wd[i];
      end
    end
  end

`ifdef ID_FWD_EN
  assign data = (src == '0) ? '0 : (match ? fwd_data : rf_rdata);
`else
  logic [DATA_W-1:0] unused_fwd_data;
  assign unused_fwd_data = fwd_data;
  assign data = (src == '0) ? '0 : rf_rdata;
`endif

endmodule

// File: rtl/id_bypass_ctrl.sv
// rtl/id_bypass_ctrl.sv - decode-stage operand bypass, load-use interlock and stall counter
//
// Macro: ID_FWD_EN enables operand bypass; undefined, any pending write to a
// source in fwd_bus also interlocks until the register file holds the value.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid, rs, rt         decode slot and its source addresses
//   use_rs, use_rt           instruction reads that source
//   is_load, rf_we, rf_waddr destination info of the decode instruction
//   rf_rdata1, rf_rdata2     register file read data
//   fwd_bus                  NUM_FWD {we, waddr, wdata} entries, entry 0 youngest (MSB)
//   ex_stall, flush          downstream hold, squash
//   rdata1, rdata2           bypassed operands
//   stallreq, issue          interlock request, instruction leaves ID
//   stall_cnt                saturating count of stallreq cycles

import id_bypass_ctrl_pkg::*;

module id_bypass_ctrl #(
  parameter int DATA_W   = 32,
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    id_valid,
  input  logic [REG_AW-1:0]                       rs,
  input  logic [REG_AW-1:0]                       rt,
  input  logic                                    use_rs,
  input  logic                                    use_rt,
  input  logic                                    is_load,
  input  logic                                    rf_we,
  input  logic [REG_AW-1:0]                       rf_waddr,
  input  logic [DATA_W-1:0]                       rf_rdata1,
  input  logic [DATA_W-1:0]                       rf_rdata2,
  input  logic [NUM_FWD*fwd_entry_wd(DATA_W)-1:0] fwd_bus,
  input  logic                                    ex_stall,
  input  logic                                    flush,
  output logic [DATA_W-1:0]                       rdata1,
  output logic [DATA_W-1:0]                       rdata2,
  output logic                                    stallreq,
  output logic                                    issue,
  output logic [31:0]                             stall_cnt
);

  if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_lat
    $error("id_bypass_ctrl: LOAD_LAT out of range");
  end

  logic match_rs, match_rt;

  id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_mux_rs (
    .src(rs), .fwd_bus(fwd_bus), .rf_rdata(rf_rdata1), .data(rdata1), .match(match_rs)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_mux_rt (
    .src(rt), .fwd_bus(fwd_bus), .rf_rdata(rf_rdata2), .data(rdata2), .match(match_rt)
  );

  // Shadow of issued loads whose data is not yet forwardable.
  logic [LOAD_LAT-1:0]             sh_v;
  logic [LOAD_LAT-1:0][REG_AW-1:0] sh_addr;
  logic                            sh_hit_rs, sh_hit_rt;
  logic                            pend_rs, pend_rt;
  logic                            haz_rs, haz_rt;
  logic                            ld_new;

  always_comb begin
    sh_hit_rs = 1'b0;
    sh_hit_rt = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (sh_v[k] && (sh_addr[k] == rs)) sh_hit_rs = 1'b1;
      if (sh_v[k] && (sh_addr[k] == rt)) sh_hit_rt = 1'b1;
    end
  end

`ifdef ID_FWD_EN
  logic unused_match;
  assign unused_match = match_rs | match_rt;
  assign pend_rs = 1'b0;
  assign pend_rt = 1'b0;
`else
  // Without bypass, an in-flight write is as blocking as an unfinished load.
  assign pend_rs = match_rs;
  assign pend_rt = match_rt;
`endif

  assign haz_rs = use_rs & (rs != '0) & (sh_hit_rs | pend_rs);
  assign haz_rt = use_rt & (rt != '0) & (sh_hit_rt | pend_rt);

  // rst gates the outputs directly so they drop the moment reset asserts.
  assign stallreq = rst & id_valid & ~flush & (haz_rs | haz_rt);
  assign issue    = rst & id_valid & ~stallreq & ~ex_stall & ~flush;
  assign ld_new   = issue & is_load & rf_we & (rf_waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_v    <= '0;
      sh_addr <= '0;
    end else if (flush) begin
      sh_v <= '0;
    end else if (!ex_stall) begin
      sh_v[0]    <= ld_new;
      sh_addr[0] <= rf_waddr;
      for (int k = 1; k < LOAD_LAT; k++) begin
        sh_v[k]    <= sh_v[k-1];
        sh_addr[k] <= sh_addr[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stallreq && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_bypass_ctrl.sv
// tb/tb_id_bypass_ctrl.sv - self-checking bench for id_bypass_ctrl against a queue-based model

module tb_id_bypass_ctrl;

  localparam int DW = 32;
  localparam int NF = 3;
  localparam int LL = 1;
  localparam int EW = 1 + 5 + DW;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid;
  logic [4:0]     rs, rt;
  logic           use_rs, use_rt;
  logic           is_load, rf_we;
  logic [4:0]     rf_waddr;
  logic [DW-1:0]  rf_rdata1, rf_rdata2;
  logic [NF*EW-1:0] fwd_bus;
  logic           ex_stall, flush;
  logic [DW-1:0]  rdata1, rdata2;
  logic           stallreq, issue;
  logic [31:0]    stall_cnt;

  always #5 clk = ~clk;

  id_bypass_ctrl #(.DATA_W(DW), .NUM_FWD(NF), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .is_load(is_load), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_bus(fwd_bus), .ex_stall(ex_stall), .flush(flush),
    .rdata1(rdata1), .rdata2(rdata2), .stallreq(stallreq), .issue(issue),
    .stall_cnt(stall_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Forwarding entries as the bench sees them; packed into fwd_bus before each cycle.
  logic          f_we [NF];
  logic [4:0]    f_wa [NF];
  logic [DW-1:0] f_wd [NF];

  // Model: loads that issued and have not yet aged LL unstalled cycles.
  int          ld_addr[$];
  int          ld_age[$];
  logic [31:0] m_cnt;

  logic          s_stallreq, s_issue;
  logic [DW-1:0] s_rdata1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ld_addr.delete();
    ld_age.delete();
    m_cnt = 32'd0;
  endtask

  task automatic pack_fwd();
    for (int i = 0; i < NF; i++) fwd_bus[(NF-i)*EW-1 -: EW] = {f_we[i], f_wa[i], f_wd[i]};
  endtask

  function automatic logic [DW-1:0] m_operand(input logic [4:0] src, input logic [DW-1:0] rf);
    if (src == 5'd0) return '0;
`ifdef ID_FWD_EN
    for (int i = 0; i < NF; i++)
      if (f_we[i] && f_wa[i] != 5'd0 && f_wa[i] == src) return f_wd[i];
`endif
    return rf;
  endfunction

  function automatic bit m_hazard(input logic [4:0] src, input logic use_src);
    if (!use_src || src == 5'd0) return 1'b0;
    foreach (ld_addr[j]) if (ld_addr[j] == int'(src)) return 1'b1;
`ifndef ID_FWD_EN
    for (int i = 0; i < NF; i++)
      if (f_we[i] && f_wa[i] == src) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    bit exp_stall, exp_issue;
    int na[$];
    int ng[$];
    pack_fwd();
    @(negedge clk);
    exp_stall = rst && id_valid && !flush && (m_hazard(rs, use_rs) || m_hazard(rt, use_rt));
    exp_issue = rst && id_valid && !exp_stall && !ex_stall && !flush;
    chk("rdata1", rdata1, m_operand(rs, rf_rdata1));
    chk("rdata2", rdata2, m_operand(rt, rf_rdata2));
    chk("stallreq", stallreq, exp_stall);
    chk("issue", issue, exp_issue);
    chk("stall_cnt", stall_cnt, m_cnt);
    s_stallreq = stallreq;
    s_issue    = issue;
    s_rdata1   = rdata1;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        ld_addr.delete();
        ld_age.delete();
      end else if (!ex_stall) begin
        foreach (ld_age[j]) begin
          if (ld_age[j] + 1 < LL) begin
            na.push_back(ld_addr[j]);
            ng.push_back(ld_age[j] + 1);
          end
        end
        ld_addr = na;
        ld_age  = ng;
        if (exp_issue && is_load && rf_we && rf_waddr != 5'd0) begin
          ld_addr.push_back(int'(rf_waddr));
          ld_age.push_back(0);
        end
      end
    end
    #1;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; rs = '0; rt = '0; use_rs = 1'b0; use_rt = 1'b0;
    is_load = 1'b0; rf_we = 1'b0; rf_waddr = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; ex_stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < NF; i++) begin f_we[i] = 1'b0; f_wa[i] = '0; f_wd[i] = '0; end
  endtask

  task automatic consumer(input logic [4:0] src, input logic [DW-1:0] rfv);
    id_valid = 1'b1; is_load = 1'b0; rf_we = 1'b1; rf_waddr = 5'd6;
    rs = src; use_rs = 1'b1; rt = 5'd7; use_rt = 1'b1;
    rf_rdata1 = rfv; rf_rdata2 = 32'h77;
  endtask

  task automatic load(input logic [4:0] dst);
    id_valid = 1'b1; is_load = 1'b1; rf_we = 1'b1; rf_waddr = dst;
    rs = 5'd1; use_rs = 1'b1; rt = 5'd0; use_rt = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    chk("rst_stallreq", stallreq, 1'b0);
    chk("rst_issue", issue, 1'b0);
    chk("rst_cnt", stall_cnt, 32'd0);
    model_reset();
    cycle();
    rst = 1'b1;
  endtask

  logic [31:0] c0;

  initial begin
    set_idle();
    fwd_bus = '0;
    model_reset();
    rst = 1'b0;
    id_valid = 1'b1; rs = 5'd5; use_rs = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    set_idle();
    cycle();

    // Load-use: lw $5 followed by a $5 consumer
    load(5'd5);
    cycle();
    consumer(5'd5, 32'h1111);
    f_we[0] = 1'b1; f_wa[0] = 5'd5; f_wd[0] = 32'hDEAD_BEEF;
    cycle();
    chk("lu_stall", s_stallreq, 1'b1);
    chk("lu_cnt", stall_cnt, 32'd1);
    f_we[0] = 1'b0;
    f_we[1] = 1'b1; f_wa[1] = 5'd5; f_wd[1] = 32'h1234_5678;
    cycle();
`ifdef ID_FWD_EN
    chk("lu_issue", s_issue, 1'b1);
    chk("lu_rdata1", s_rdata1, 32'h1234_5678);
`else
    chk("lu_wait", s_stallreq, 1'b1);
    f_we[1] = 1'b0;
    f_we[2] = 1'b1; f_wa[2] = 5'd5; f_wd[2] = 32'h1234_5678;
    cycle();
    f_we[2] = 1'b0;
    cycle();
    chk("lu_issue", s_issue, 1'b1);
    chk("lu_rdata1", s_rdata1, 32'h1111);
`endif

    // EX and MEM both write $3
    set_idle();
    consumer(5'd3, 32'h3333);
    f_we[0] = 1'b1; f_wa[0] = 5'd3; f_wd[0] = 32'hA;
    f_we[1] = 1'b1; f_wa[1] = 5'd3; f_wd[1] = 32'hB;
    cycle();
`ifdef ID_FWD_EN
    chk("prio_rdata1", s_rdata1, 32'hA);
    chk("prio_stall", s_stallreq, 1'b0);
`else
    chk("prio_stall", s_stallreq, 1'b1);
`endif

    // $0 never forwards or stalls
    set_idle();
    consumer(5'd0, 32'h5555);
    f_we[0] = 1'b1; f_wa[0] = 5'd0; f_wd[0] = 32'hFFFF_FFFF;
    cycle();
    chk("zero_rdata1", s_rdata1, 32'd0);
    chk("zero_stall", s_stallreq, 1'b0);

    // Load $4, then ex_stall for 3 cycles with a $4 consumer
    set_idle();
    load(5'd4);
    cycle();
    consumer(5'd4, 32'h4444);
    ex_stall = 1'b1;
    c0 = stall_cnt;
    for (int k = 0; k < 3; k++) cycle();
    chk("hold_stall", s_stallreq, 1'b1);
    chk("hold_cnt", stall_cnt - c0, 32'd3);
    ex_stall = 1'b0;
    cycle();
    cycle();
    chk("hold_issue", s_issue, 1'b1);

    // Load $9 then flush with ex_stall
    set_idle();
    load(5'd9);
    cycle();
    id_valid = 1'b1; is_load = 1'b0; flush = 1'b1; ex_stall = 1'b1;
    cycle();
    flush = 1'b0; ex_stall = 1'b0;
    consumer(5'd9, 32'h9999);
    cycle();
    chk("flush_stall", s_stallreq, 1'b0);
    chk("flush_issue", s_issue, 1'b1);

    // WB writes $2 while ID reads $2; reset hits mid-sequence
    set_idle();
    consumer(5'd2, 32'h2222);
    f_we[2] = 1'b1; f_wa[2] = 5'd2; f_wd[2] = 32'h22;
    cycle();
    cycle();
    async_reset();
    f_we[2] = 1'b0;
    cycle();
    chk("wb_issue", s_issue, 1'b1);
    chk("wb_rdata1", s_rdata1, 32'h2222);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      id_valid  = ($urandom_range(0, 7) != 0);
      rs        = 5'($urandom_range(0, 7));
      rt        = 5'($urandom_range(0, 7));
      use_rs    = 1'($urandom_range(0, 1));
      use_rt    = 1'($urandom_range(0, 1));
      is_load   = ($urandom_range(0, 2) == 0);
      rf_we     = ($urandom_range(0, 3) != 0);
      rf_waddr  = 5'($urandom_range(0, 7));
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      ex_stall  = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NF; i++) begin
        f_we[i] = 1'($urandom_range(0, 1));
        f_wa[i] = 5'($urandom_range(0, 7));
        f_wd[i] = $urandom;
      end
      if ($urandom_range(0, 149) == 0) begin
        pack_fwd();
        async_reset();
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
